gpu_ext_bridge: RTL and testbench
=================================

// Module: gpu_ext_bridge
// PURPOSE
//  System-bus responder for the GPU/DSP local memory controller's external requests.
//  Accepts one external access (address, size, direction, data) at a time and arbitrates
//  for the 32-bit big-endian system bus. Runs a strobed bus cycle with wait states,
//  then returns read data and a one-cycle ack to the controller.
//  Sits between the GPU memory controller's external port and the system bus arbiter.
// PARAMETERS
//  TIMEOUT   16   bus cycles allowed in DATA before abort (used only with GPU_EXT_TIMEOUT_EN)
// PORTS
//  clk          in   1   system clock; every flop is on its rising edge
//  reset_n      in   1   asynchronous active-low reset
//  ext_req      in   1   level request from GPU memory controller
//  ext_addr     in   24  byte address of access
//  ext_we       in   1   1 = write, 0 = read
//  ext_size     in   2   00 byte, 01 word (16b), 10 long (32b), 11 treated as long
//  ext_wdata    in   32  write data, right-justified (byte in [7:0], word in [15:0])
//  ext_ack      out  1   one-cycle completion pulse
//  ext_rdata    out  32  read data, right-justified, zero-extended; valid while ext_ack=1
//  ext_busy     out  1   1 whenever state != IDLE
//  bus_req      out  1   bus request to arbiter
//  bus_gnt      in   1   bus grant
//  bus_addr     out  24  bus address; [1:0] forced per size rules
//  bus_rw       out  1   1 = read, 0 = write
//  bus_be       out  4   byte enables, be[3] = bits [31:24] = lowest byte address
//  bus_strobe   out  1   cycle strobe
//  bus_wdata    out  32  lane-replicated write data
//  bus_rdata    in   32  read data
//  bus_ready    in   1   slave ready / cycle termination
//  bus_err      out  1   one-cycle pulse with ext_ack on timeout abort (0 without macro)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except bus_rw = 1. Reset mid-cycle drops bus_req and
//   bus_strobe immediately; the in-flight access is lost and not acked.
//  FSM states: IDLE -> REQ -> ADDR -> DATA -> ACK -> IDLE.
//   IDLE: when ext_req = 1, latch addr/we/size/wdata, go to REQ.
//   REQ: bus_req = 1; when bus_gnt = 1, go to ADDR. A grant dropped while in REQ keeps the
//    FSM in REQ.
//   ADDR: bus_addr, bus_rw, bus_be and bus_wdata are driven; bus_strobe = 1; always one
//    cycle, then DATA.
//   DATA: bus_strobe is held. On bus_ready = 1, capture read data and go to ACK.
//    bus_gnt is ignored from ADDR onward.
//   ACK: ext_ack = 1 for exactly one cycle; bus_req, bus_strobe and bus_be go to 0;
//    then IDLE.
//  Minimum latency: with gnt and ready held high, ext_ack rises 4 clocks after the
//   edge that samples ext_req.
//  Requester must drop ext_req at the edge that ends ACK. A new request is sampled
//   only in IDLE, so back-to-back accesses cost 5 clocks each.
//  Lane rules (big-endian): byte: be = 4'b1000 >> addr[1:0]; wdata byte replicated on all
//   four lanes; rdata = selected lane. Word: addr[0] ignored; be = addr[1] ? 0011 : 1100;
//   wdata halfword replicated. Long: bus_addr[1:0] = 00, be = 1111.
//  Bus outputs (addr, rw, be, wdata) are registered and stable from ADDR through DATA.
// CONFIGURATION
//  GPU_EXT_TIMEOUT_EN defined:
//   - a counter clears on entry to DATA and counts each DATA cycle without bus_ready;
//   - at TIMEOUT cycles the FSM goes to ACK with ext_rdata = 32'hFFFFFFFF and
//     bus_err = 1 alongside ext_ack;
//   - bus_ready arriving on the expiry cycle wins (normal completion).
//  Not defined: DATA waits indefinitely; bus_err is tied 0; no counter logic.
// STRUCTURE
//  Package gpu_ext_pkg:
//   - state enum (IDLE, REQ, ADDR, DATA, ACK);
//   - size codes SZ_BYTE, SZ_WORD, SZ_LONG;
//   - function be_for(size, addr[1:0]).
//  Sub-module gpu_ext_lanes (combinational): write replication, be generation,
//   read-lane extraction.
//  Top module holds the FSM, latches and timeout counter.
// TESTING
//  1. Long read 0x001000, gnt and ready high -> ext_ack 4 clks after sample;
//     rdata = bus_rdata; be = 1111.
//  2. Byte write 0xA5 at 0x000003 -> bus_be = 0001; bus_wdata = 0xA5A5A5A5;
//     bus_addr = 0x000003; bus_rw = 0.
//  3. Word read at 0x000002, bus_rdata = 0x1234ABCD -> be = 0011; ext_rdata = 0x0000ABCD.
//  4. bus_gnt withheld 7 clks, then bus_ready delayed 3 clks -> strobe held 4 clks;
//     a single ext_ack; no second bus_req.
//  5. reset_n low during DATA -> bus_req and bus_strobe 0 before the next edge;
//     no ext_ack; a fresh request after reset completes normally.
//  6. (GPU_EXT_TIMEOUT_EN) ready never asserted -> ack after 16 DATA clks;
//     rdata = 0xFFFFFFFF; bus_err = 1 for one clk.

Source files
------------

// File: rtl/gpu_ext_pkg.sv
// Shared types and lane helpers for the GPU external-access bus bridge.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package gpu_ext_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        ADDR = 3'd2,
        DATA = 3'd3,
        ACK  = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_LONG = 2'b10;

    // Big-endian byte enables: be[3] is the lane at the lowest byte address.
    // Size code 2'b11 falls through to the long case.
    function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b1000 >> addr_lo;
            SZ_WORD: be = addr_lo[1] ? 4'b0011 : 4'b1100;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/gpu_ext_lanes.sv
// Big-endian lane steering: write replication, byte enables, read-lane extraction.
// Latency: purely combinational.
// Backpressure: none; follows its inputs every cycle.
module gpu_ext_lanes
    import gpu_ext_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  be,
    output logic [31:0] bus_wdata,
    output logic [31:0] rdata
);

    // Replicate the right-justified write data and pick the addressed read lane.
    always_comb begin
        be        = be_for(size, addr_lo);
        bus_wdata = wdata;
        rdata     = bus_rdata;
        case (size)
            SZ_BYTE: begin
                bus_wdata = {4{wdata[7:0]}};
                case (addr_lo)
                    2'd0:    rdata = {24'd0, bus_rdata[31:24]};
                    2'd1:    rdata = {24'd0, bus_rdata[23:16]};
                    2'd2:    rdata = {24'd0, bus_rdata[15:8]};
                    default: rdata = {24'd0, bus_rdata[7:0]};
                endcase
            end
            SZ_WORD: begin
                bus_wdata = {2{wdata[15:0]}};
                rdata     = addr_lo[1] ? {16'd0, bus_rdata[15:0]} : {16'd0, bus_rdata[31:16]};
            end
            default: begin
                bus_wdata = wdata;
                rdata     = bus_rdata;
            end
        endcase
    end

endmodule

// File: rtl/gpu_ext_bridge.sv
// GPU external-access responder: one strobed 32-bit big-endian system-bus cycle per request.
// Latency: ext_ack seen at the 4th edge after ext_req is sampled, plus grant and wait states.
// Backpressure: holds in REQ until bus_gnt and in DATA until bus_ready (GPU_EXT_TIMEOUT_EN adds an abort).
module gpu_ext_bridge
    import gpu_ext_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ext_req,
    input  logic [23:0] ext_addr,
    input  logic        ext_we,
    input  logic [1:0]  ext_size,
    input  logic [31:0] ext_wdata,
    output logic        ext_ack,
    output logic [31:0] ext_rdata,
    output logic        ext_busy,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [23:0] bus_addr,
    output logic        bus_rw,
    output logic [3:0]  bus_be,
    output logic        bus_strobe,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic        bus_err
);

    state_t      state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;

    logic        bus_req_q, bus_req_d;
    logic        bus_strobe_q, bus_strobe_d;
    logic        bus_rw_q, bus_rw_d;
    logic [23:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        ext_ack_q, ext_ack_d;
    logic [31:0] ext_rdata_q, ext_rdata_d;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic [23:0] aligned_addr;

`ifdef GPU_EXT_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             bus_err_q, bus_err_d;
`endif

    gpu_ext_lanes u_lanes (
        .size      (size_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .bus_rdata (bus_rdata),
        .be        (lane_be),
        .bus_wdata (lane_wdata),
        .rdata     (lane_rdata)
    );

    // Low address bits follow the access size: words drop bit 0, longs are fully aligned.
    always_comb begin
        case (size_q)
            SZ_BYTE: aligned_addr = addr_q;
            SZ_WORD: aligned_addr = {addr_q[23:1], 1'b0};
            default: aligned_addr = {addr_q[23:2], 2'b00};
        endcase
    end

    // Next-state and next-output logic for the IDLE->REQ->ADDR->DATA->ACK sequence.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        bus_req_d    = bus_req_q;
        bus_strobe_d = bus_strobe_q;
        bus_rw_d     = bus_rw_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        ext_ack_d    = 1'b0;
        ext_rdata_d  = ext_rdata_q;
`ifdef GPU_EXT_TIMEOUT_EN
        tmo_d        = tmo_q;
        bus_err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ext_req) begin
                    state_d   = REQ;
                    addr_d    = ext_addr;
                    we_d      = ext_we;
                    size_d    = ext_size;
                    wdata_d   = ext_wdata;
                    bus_req_d = 1'b1;
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    state_d      = ADDR;
                    bus_strobe_d = 1'b1;
                    bus_addr_d   = aligned_addr;
                    bus_rw_d     = ~we_q;
                    bus_be_d     = lane_be;
                    bus_wdata_d  = lane_wdata;
                end
            end
            ADDR: begin
                state_d = DATA;
`ifdef GPU_EXT_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            DATA: begin
                if (bus_ready) begin
                    state_d      = ACK;
                    ext_ack_d    = 1'b1;
                    ext_rdata_d  = lane_rdata;
                    bus_req_d    = 1'b0;
                    bus_strobe_d = 1'b0;
                    bus_be_d     = 4'b0000;
                end
`ifdef GPU_EXT_TIMEOUT_EN
                // Ready on the expiry cycle is handled above and completes normally.
                else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d      = ACK;
                    ext_ack_d    = 1'b1;
                    ext_rdata_d  = 32'hFFFF_FFFF;
                    bus_err_d    = 1'b1;
                    bus_req_d    = 1'b0;
                    bus_strobe_d = 1'b0;
                    bus_be_d     = 4'b0000;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state and registered outputs; reset drops the bus request and strobe immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            size_q       <= '0;
            wdata_q      <= '0;
            bus_req_q    <= 1'b0;
            bus_strobe_q <= 1'b0;
            bus_rw_q     <= 1'b1;
            bus_addr_q   <= '0;
            bus_be_q     <= '0;
            bus_wdata_q  <= '0;
            ext_ack_q    <= 1'b0;
            ext_rdata_q  <= '0;
`ifdef GPU_EXT_TIMEOUT_EN
            tmo_q        <= '0;
            bus_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            bus_req_q    <= bus_req_d;
            bus_strobe_q <= bus_strobe_d;
            bus_rw_q     <= bus_rw_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            ext_ack_q    <= ext_ack_d;
            ext_rdata_q  <= ext_rdata_d;
`ifdef GPU_EXT_TIMEOUT_EN
            tmo_q        <= tmo_d;
            bus_err_q    <= bus_err_d;
`endif
        end
    end

    assign ext_ack    = ext_ack_q;
    assign ext_rdata  = ext_rdata_q;
    assign ext_busy   = (state_q != IDLE);
    assign bus_req    = bus_req_q;
    assign bus_addr   = bus_addr_q;
    assign bus_rw     = bus_rw_q;
    assign bus_be     = bus_be_q;
    assign bus_strobe = bus_strobe_q;
    assign bus_wdata  = bus_wdata_q;
`ifdef GPU_EXT_TIMEOUT_EN
    assign bus_err    = bus_err_q;
`else
    assign bus_err    = 1'b0;
`endif

endmodule

// File: tb/tb_gpu_ext_bridge.sv
// Randomized and directed bench for gpu_ext_bridge against a byte-level bus model.
// Latency: transactions are paced by the bench's own grant/ready delays.
// Backpressure: the bench plays arbiter and slave, withholding grant and ready.
`timescale 1ns/1ps
module tb_gpu_ext_bridge;

    localparam int TMO    = 16;
    localparam int BUDGET = 200;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ext_req = 1'b0;
    logic [23:0] ext_addr = '0;
    logic        ext_we = 1'b0;
    logic [1:0]  ext_size = '0;
    logic [31:0] ext_wdata = '0;
    logic        ext_ack;
    logic [31:0] ext_rdata;
    logic        ext_busy;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic [23:0] bus_addr;
    logic        bus_rw;
    logic [3:0]  bus_be;
    logic        bus_strobe;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_ready = 1'b0;
    logic        bus_err;

    int n_chk  = 0;
    int n_fail = 0;

    gpu_ext_bridge #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ext_req    (ext_req),
        .ext_addr   (ext_addr),
        .ext_we     (ext_we),
        .ext_size   (ext_size),
        .ext_wdata  (ext_wdata),
        .ext_ack    (ext_ack),
        .ext_rdata  (ext_rdata),
        .ext_busy   (ext_busy),
        .bus_req    (bus_req),
        .bus_gnt    (bus_gnt),
        .bus_addr   (bus_addr),
        .bus_rw     (bus_rw),
        .bus_be     (bus_be),
        .bus_strobe (bus_strobe),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ready  (bus_ready),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Byte-level view of a big-endian access: which byte addresses it touches and
    // how those bytes map onto the four lanes of the 32-bit bus.
    function automatic void model(input logic [23:0] a, input logic [1:0] sz,
                                  input logic [31:0] wd, input logic [31:0] rd,
                                  output logic [23:0] ba, output logic [3:0] be,
                                  output logic [31:0] bw, output logic [31:0] rr);
        int nb;
        int first;
        nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        first = (int'(a[1:0]) / nb) * nb;
        ba    = {a[23:2], 2'(first)};
        be    = '0;
        rr    = '0;
        for (int k = 0; k < nb; k++) begin
            be[3 - (first + k)] = 1'b1;
            rr = (rr << 8) | {24'd0, rd[8*(3 - (first + k)) +: 8]};
        end
        for (int l = 0; l < 4; l++) bw[8*l +: 8] = wd[8*(l % nb) +: 8];
    endfunction

    // One access; the bench acts as arbiter (grant after gnt_dly REQ cycles) and as
    // slave (ready after rdy_dly DATA wait cycles). lat = observation index of ext_ack.
    task automatic run_txn(input logic [23:0] a, input logic we, input logic [1:0] sz,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int gnt_dly, input int rdy_dly, output int lat);
        logic [23:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
        logic        tmo;
        int data_cyc, exp_lat, k, n_req, n_str, n_ack;
        model(a, sz, wd, rd, e_addr, e_be, e_wd, e_rd);
`ifdef GPU_EXT_TIMEOUT_EN
        tmo = (rdy_dly >= TMO);
`else
        tmo = 1'b0;
`endif
        data_cyc = tmo ? TMO : rdy_dly + 1;
        if (tmo) e_rd = 32'hFFFF_FFFF;
        exp_lat = (gnt_dly + 1) + 1 + data_cyc + 1;

        @(negedge clk);
        ext_req = 1'b1; ext_addr = a; ext_we = we; ext_size = sz; ext_wdata = wd;
        bus_rdata = rd; bus_gnt = 1'b0; bus_ready = 1'b0;
        @(posedge clk);
        k = 0; n_req = 0; n_str = 0; n_ack = 0;
        while (n_ack == 0 && k < BUDGET) begin
            @(negedge clk);
            k++;
            if (ext_ack) begin
                n_ack++;
                ext_req = 1'b0;
                chk("ack_latency", k, exp_lat);
                if (!we || tmo) chk("ack_rdata", ext_rdata, e_rd);
                chk("ack_err", {31'd0, bus_err}, {31'd0, tmo});
                chk("ack_busy", {31'd0, ext_busy}, 32'd1);
                chk("ack_bus_idle", {25'd0, bus_req, bus_strobe, bus_be}, 32'd0);
                chk("req_cycles", n_req, gnt_dly + 1);
                chk("strobe_cycles", n_str, data_cyc + 1);
            end else begin
                chk("busy", {31'd0, ext_busy}, 32'd1);
                chk("bus_req_held", {31'd0, bus_req}, 32'd1);
                if (bus_strobe) begin
                    n_str++;
                    chk("bus_addr", bus_addr, e_addr);
                    chk("bus_be", bus_be, e_be);
                    chk("bus_rw", {31'd0, bus_rw}, {31'd0, ~we});
                    chk("bus_wdata", bus_wdata, e_wd);
                    bus_gnt   = 1'($urandom_range(0, 1));
                    bus_ready = (n_str == 1) ? 1'($urandom_range(0, 1)) : (n_str - 2 >= rdy_dly);
                end else begin
                    n_req++;
                    bus_gnt = (n_req > gnt_dly);
                end
            end
        end
        if (n_ack == 0) chk("ack_within_budget", 32'd0, 32'd1);
        lat = k;
        ext_req = 1'b0; bus_gnt = 1'b0; bus_ready = 1'b0;
        @(negedge clk);
        chk("post_ack_pulse", {31'd0, ext_ack}, 32'd0);
        chk("post_ack_idle", {29'd0, ext_busy, bus_req, bus_strobe}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] m_addr;
        logic [3:0]  m_be;
        logic [31:0] m_wd, m_rd;
        int lat;

        // Pin the model on hand-computed lane cases.
        model(24'h001000, 2'b10, 32'h0, 32'hDEADBEEF, m_addr, m_be, m_wd, m_rd);
        chk("pin_long_be", m_be, 4'b1111);
        chk("pin_long_rdata", m_rd, 32'hDEADBEEF);
        model(24'h000003, 2'b00, 32'h000000A5, 32'h0, m_addr, m_be, m_wd, m_rd);
        chk("pin_byte_be", m_be, 4'b0001);
        chk("pin_byte_wdata", m_wd, 32'hA5A5A5A5);
        chk("pin_byte_addr", m_addr, 24'h000003);
        model(24'h000002, 2'b01, 32'h0, 32'h1234ABCD, m_addr, m_be, m_wd, m_rd);
        chk("pin_word_be", m_be, 4'b0011);
        chk("pin_word_rdata", m_rd, 32'h0000ABCD);
        model(24'h000401, 2'b01, 32'h0000BEEF, 32'h1234ABCD, m_addr, m_be, m_wd, m_rd);
        chk("pin_word_odd_addr", m_addr, 24'h000400);
        chk("pin_word_odd_be", m_be, 4'b1100);
        chk("pin_word_wdata", m_wd, 32'hBEEFBEEF);

        // Reset state.
        #22;
        chk("rst_ack", {31'd0, ext_ack}, 32'd0);
        chk("rst_rdata", ext_rdata, 32'd0);
        chk("rst_busy", {31'd0, ext_busy}, 32'd0);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_addr", bus_addr, 24'd0);
        chk("rst_bus_rw", {31'd0, bus_rw}, 32'd1);
        chk("rst_bus_be", bus_be, 4'd0);
        chk("rst_bus_strobe", {31'd0, bus_strobe}, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed accesses.
        run_txn(24'h001000, 1'b0, 2'b10, 32'h0, 32'hDEADBEEF, 0, 0, lat);
        chk("t1_min_latency", lat, 4);
        run_txn(24'h000003, 1'b1, 2'b00, 32'h000000A5, 32'h0, 0, 0, lat);
        run_txn(24'h000002, 1'b0, 2'b01, 32'h0, 32'h1234ABCD, 0, 0, lat);
        run_txn(24'h00F00D, 1'b0, 2'b10, 32'h0, 32'hCAFEF00D, 7, 2, lat);
        chk("t4_latency", lat, 13);

        // Reset while the bus cycle is in DATA.
        @(negedge clk);
        ext_req = 1'b1; ext_addr = 24'h00ABCC; ext_we = 1'b0; ext_size = 2'b10;
        bus_gnt = 1'b1; bus_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mid_in_data", {30'd0, bus_strobe, bus_req}, 32'd3);
        reset_n = 1'b0;
        ext_req = 1'b0;
        #1;
        chk("rst_mid_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_mid_strobe", {31'd0, bus_strobe}, 32'd0);
        chk("rst_mid_busy", {31'd0, ext_busy}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bus_gnt = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_no_ack", {31'd0, ext_ack}, 32'd0);
        end
        run_txn(24'h000101, 1'b0, 2'b00, 32'h0, 32'h11223344, 1, 1, lat);

        // Slave never ready within the timeout window (plain wait without the abort).
        run_txn(24'h002000, 1'b0, 2'b10, 32'h0, 32'h55AA55AA, 0, 40, lat);
        // Ready on the last permitted DATA cycle.
        run_txn(24'h002004, 1'b0, 2'b10, 32'h0, 32'h0BADC0DE, 0, TMO - 1, lat);

        // Randomized accesses.
        for (int i = 0; i < 60; i++) begin
            run_txn(24'($urandom), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    $urandom, $urandom, $urandom_range(0, 6),
                    ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4), lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
